irq_priority_encoder: RTL and testbench
=======================================

Name: irq_priority_encoder

Overview:
- 8-line request-to-index encoder; the inverse of the 3-to-8 one-hot decoder used for register/device select.
- Captures rising edges on 8 request lines into a pending register, masks them, and priority-encodes the highest pending line into a 3-bit code.
- Holds each code under a valid/ack handshake until the consumer (control unit / interrupt logic of the RISC core) acknowledges it.
- Keeps sticky overrun flags for lost edges.

Parameters:
- N, 8, number of request lines; fixed at 8 for this revision.
- CODE_W, 3, width of the encoded index; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  request lines, level inputs, synchronous to clk; rising edges are captured.
- mask_we  input  1  when 1, mask register loads mask_in at the clock edge.
- mask_in  input  N  new mask value; 1 = line masked.
- ack  input  1  consumer accepts the presented code; honoured only while valid_out=1.
- ovr_clr  input  1  clears all overrun flags.
- code_out  output  CODE_W  index of the presented request; bit 7 is highest priority.
- valid_out  output  1  code_out is valid and held stable.
- pending_out  output  N  current pending register.
- mask_out  output  N  current mask register.
- overrun_out  output  N  sticky per-line overrun flags.

Behaviour:
- Reset (rst=1 at clock edge): code_out=0, valid_out=0, pending=0, mask=0, overrun=0, req_q=0, state=IDLE. Reset mid-handshake drops the presented code without clearing anything further.
- Because req_q resets to 0, a line held high through reset registers as an edge on the first cycle after reset.
- Edge detect: req_q <= req_in each cycle; edge = req_in & ~req_q.
- Clear vector: clr = one-hot(code_out) when (state=PRESENT and ack), else 0.
- Pending update: pending <= (pending & ~clr) | edge. Set wins over clear, so an edge on the acknowledged line in the ack cycle leaves that bit pending.
- Overrun: overrun[i] <= 1 when edge[i] and pending[i] and not clr[i].
  - ovr_clr clears all flags.
  - If ovr_clr and a new overrun occur in the same cycle, the set wins.
- Mask: mask <= mask_in when mask_we. Masked lines still capture into pending but are not presented.
- Eligible vector: elig = pending & ~mask, using register values. Encoder selects the highest set index of elig.
- State IDLE:
  - valid_out=0.
  - If elig != 0 at the clock edge: code_out <= encoded index, valid_out <= 1, go to PRESENT.
  - Otherwise stay in IDLE; code_out holds its last value.
- State PRESENT:
  - valid_out=1; code_out stable regardless of new edges or mask writes.
  - On ack: clear that pending bit (per the clear rule), valid_out <= 0, go to IDLE.
  - Without ack: stay in PRESENT.
- Ack while in IDLE is ignored and has no side effects.
- Latency: req_in rises before edge k → pending set after edge k → valid_out=1 after edge k+1 (2 cycles).
- After an ack there is at least one IDLE cycle (valid_out=0) before the next code is presented. Back-to-back service therefore takes 2 cycles per request.
- Masking a line while it is presented does not withdraw it; it is still cleared by ack.
- Unmasking a pending line makes it eligible at the next IDLE evaluation.

Test Plan:
- Reset, then raise req_in=8'h01 and hold: pending=8'h01 after 1 edge; code_out=0, valid_out=1 after 2 edges. Ack → pending=0, valid_out=0; no re-trigger while the line stays high.
- Simultaneous request: req_in=8'h82 rises in one cycle → code 7 presented first. Ack → 1 idle cycle, then code 1 presented. Ack → pending=0.
- Mask: write mask=8'h80, raise req_in=8'h81 → code 0 presented, pending=8'h81. Ack, then write mask=0 → code 7 presented.
- Overrun: pulse req bit 3 twice before any ack → overrun_out=8'h08, pending=8'h08. Assert ovr_clr → overrun_out=0.
- Set-beats-clear: with code 2 presented, pulse req bit 2 rising in the same cycle as ack → pending bit 2 stays 1, overrun bit 2 stays 0, code 2 presented again after one idle cycle.
- Reset mid-operation: assert rst while valid_out=1 with pending=8'hFF and overrun=8'h10 → next cycle all outputs 0. A req_in held high through reset is then captured as a new edge.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// Interrupt request encoder: captures rising edges on N request lines, masks them,
// and presents the highest pending index under a valid/ack handshake, with sticky overrun flags.
module irq_priority_encoder #(
    parameter int N      = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_in,
    input  logic              mask_we,
    input  logic [N-1:0]      mask_in,
    input  logic              ack,
    input  logic              ovr_clr,
    output logic [CODE_W-1:0] code_out,
    output logic              valid_out,
    output logic [N-1:0]      pending_out,
    output logic [N-1:0]      mask_out,
    output logic [N-1:0]      overrun_out
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t              r_state;
    logic [N-1:0]        r_req_q;
    logic [N-1:0]        r_pending;
    logic [N-1:0]        r_mask;
    logic [N-1:0]        r_overrun;
    logic [CODE_W-1:0]   r_code;
    logic                r_valid;

    logic [N-1:0]        w_edge;
    logic [N-1:0]        w_clr;
    logic [N-1:0]        w_ovr_set;
    logic [N-1:0]        w_pending_next;
    logic [N-1:0]        w_overrun_next;
    logic [N-1:0]        w_elig;
    logic                w_ack_taken;
    logic [CODE_W-1:0]   w_enc_idx;

    assign w_ack_taken = (r_state == ST_PRESENT) && ack;
    assign w_elig      = r_pending & ~r_mask;

    // Per-line edge capture, clear and overrun; a new edge always wins over a clear.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            assign w_edge[gi]         = req_in[gi] & ~r_req_q[gi];
            assign w_clr[gi]          = w_ack_taken && (r_code == CODE_W'(gi));
            assign w_ovr_set[gi]      = w_edge[gi] & r_pending[gi] & ~w_clr[gi];
            assign w_pending_next[gi] = (r_pending[gi] & ~w_clr[gi]) | w_edge[gi];
            assign w_overrun_next[gi] = (r_overrun[gi] & ~ovr_clr) | w_ovr_set[gi];
        end
    endgenerate

    // Ascending scan so the highest set index is the one that survives.
    always_comb begin
        w_enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i]) begin
                w_enc_idx = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_overrun <= '0;
        end else begin
            r_req_q   <= req_in;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
            if (mask_we) begin
                r_mask <= mask_in;
            end
        end
    end

    // Handshake FSM; code is only loaded from IDLE so it stays stable while presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_code  <= w_enc_idx;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign code_out    = r_code;
    assign valid_out   = r_valid;
    assign pending_out = r_pending;
    assign mask_out    = r_mask;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Scoreboard bench for irq_priority_encoder: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the request/service rules.
module tb_irq_priority_encoder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in;
    logic         mask_we;
    logic [N-1:0] mask_in;
    logic         ack;
    logic         ovr_clr;
    logic [2:0]   code_out;
    logic         valid_out;
    logic [N-1:0] pending_out;
    logic [N-1:0] mask_out;
    logic [N-1:0] overrun_out;

    irq_priority_encoder #(.N(N), .CODE_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .mask_we     (mask_we),
        .mask_in     (mask_in),
        .ack         (ack),
        .ovr_clr     (ovr_clr),
        .code_out    (code_out),
        .valid_out   (valid_out),
        .pending_out (pending_out),
        .mask_out    (mask_out),
        .overrun_out (overrun_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [2:0]   code;
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic [N-1:0] ovr;
    } exp_t;

    exp_t     exp_q[$];
    int       code_q[$];
    int       checks = 0;
    int       errors = 0;

    // Behavioural model: one bit per line, plus who is being served.
    bit       m_pend[N];
    bit       m_mask[N];
    bit       m_ovr[N];
    bit       m_last_req[N];
    bit       m_serving;
    int       m_code;
    logic [N-1:0] cur_req;

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    // Apply one clock of stimulus, advance the model, and queue what the DUT must show after the edge.
    task automatic step(input bit r, input logic [N-1:0] rq, input bit mwe,
                        input logic [N-1:0] mi, input bit a, input bit oc);
        bit   served_line[N];
        bit   cand;
        int   best;
        exp_t e;
        rst = r; req_in = rq; mask_we = mwe; mask_in = mi; ack = a; ovr_clr = oc;
        cur_req = rq;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_ovr[i] = 0; m_last_req[i] = 0;
            end
            m_serving = 0;
            m_code = 0;
        end else begin
            // Search eligibility on the pre-edge state, highest line first.
            cand = 0; best = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (!cand && m_pend[i] && !m_mask[i]) begin
                    cand = 1; best = i;
                end
            end
            for (int i = 0; i < N; i++) served_line[i] = m_serving && a && (m_code == i);
            for (int i = 0; i < N; i++) begin
                bit rose;
                rose = rq[i] && !m_last_req[i];
                if (oc) m_ovr[i] = 0;
                if (rose && m_pend[i] && !served_line[i]) m_ovr[i] = 1;
                if (served_line[i]) m_pend[i] = 0;
                if (rose) m_pend[i] = 1;
                m_last_req[i] = rq[i];
                if (mwe) m_mask[i] = mi[i];
            end
            if (m_serving) begin
                if (a) m_serving = 0;
            end else if (cand) begin
                m_serving = 1;
                m_code = best;
                code_q.push_back(best);
            end
        end
        e.valid = m_serving;
        e.code  = 3'(m_code);
        e.pend  = pack(m_pend);
        e.mask  = pack(m_mask);
        e.ovr   = pack(m_ovr);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, cur_req, 0, '0, 0, 0);
    endtask

    // Hold inputs until the model is presenting, then acknowledge once.
    task automatic serve();
        int budget = 20;
        while (!m_serving && budget > 0) begin
            step(0, cur_req, 0, '0, 0, 0);
            budget--;
        end
        step(0, cur_req, 0, '0, 1, 0);
    endtask

    task automatic wait_present();
        int budget = 20;
        while (!m_serving && budget > 0) begin
            step(0, cur_req, 0, '0, 0, 0);
            budget--;
        end
    endtask

    // Monitor: compares every cycle's status and pops a code each time valid rises.
    initial begin : monitor
        exp_t e;
        bit   prev_valid = 0;
        int   want;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (valid_out !== e.valid) begin
                    errors++;
                    $display("FAIL valid_out: got %b want %b at %0t", valid_out, e.valid, $time);
                end
                checks++;
                if (code_out !== e.code) begin
                    errors++;
                    $display("FAIL code_out: got %0d want %0d at %0t", code_out, e.code, $time);
                end
                checks++;
                if (pending_out !== e.pend) begin
                    errors++;
                    $display("FAIL pending_out: got %h want %h at %0t", pending_out, e.pend, $time);
                end
                checks++;
                if (mask_out !== e.mask) begin
                    errors++;
                    $display("FAIL mask_out: got %h want %h at %0t", mask_out, e.mask, $time);
                end
                checks++;
                if (overrun_out !== e.ovr) begin
                    errors++;
                    $display("FAIL overrun_out: got %h want %h at %0t", overrun_out, e.ovr, $time);
                end
            end
            if (valid_out === 1'b1 && !prev_valid) begin
                checks++;
                if (code_q.size() == 0) begin
                    errors++;
                    $display("FAIL present: unexpected code %0d at %0t", code_out, $time);
                end else begin
                    want = code_q.pop_front();
                    if (code_out !== 3'(want)) begin
                        errors++;
                        $display("FAIL present: got code %0d want %0d at %0t", code_out, want, $time);
                    end else begin
                        $display("presented code %0d at %0t", code_out, $time);
                    end
                end
            end
            prev_valid = (valid_out === 1'b1);
        end
    end

    initial begin
        cur_req = '0;
        rst = 1'b1; req_in = '0; mask_we = 0; mask_in = '0; ack = 0; ovr_clr = 0;
        step(1, 8'h00, 0, '0, 0, 0);
        step(1, 8'h00, 0, '0, 0, 0);

        // Single held request; no re-trigger after ack.
        step(0, 8'h01, 0, '0, 0, 0);
        serve();
        idle(3);
        step(0, 8'h00, 0, '0, 0, 0);

        // Simultaneous request: 7 then 1.
        step(0, 8'h82, 0, '0, 0, 0);
        serve();
        serve();
        step(0, 8'h00, 0, '0, 0, 0);

        // Masked line still captured, presented after unmask.
        step(0, 8'h00, 1, 8'h80, 0, 0);
        step(0, 8'h81, 0, '0, 0, 0);
        serve();
        step(0, 8'h00, 1, 8'h00, 0, 0);
        serve();
        idle(2);

        // Overrun on line 3, then ovr_clr.
        step(0, 8'h08, 0, '0, 0, 0);
        step(0, 8'h00, 0, '0, 0, 0);
        step(0, 8'h08, 0, '0, 0, 0);
        step(0, 8'h00, 0, '0, 0, 0);
        step(0, 8'h00, 0, '0, 0, 1);
        serve();
        idle(2);

        // Edge on the acknowledged line in the ack cycle keeps it pending.
        step(0, 8'h04, 0, '0, 0, 0);
        step(0, 8'h00, 0, '0, 0, 0);
        wait_present();
        step(0, 8'h04, 0, '0, 1, 0);
        step(0, 8'h00, 0, '0, 0, 0);
        serve();
        idle(2);

        // Reset while presenting with pending=FF, overrun=10; held line re-captured.
        step(0, 8'hFF, 0, '0, 0, 0);
        step(0, 8'h00, 0, '0, 0, 0);
        step(0, 8'h10, 0, '0, 0, 0);
        wait_present();
        step(1, 8'h01, 0, '0, 0, 0);
        step(0, 8'h01, 0, '0, 0, 0);
        serve();
        step(0, 8'h00, 0, '0, 0, 0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] rq;
            rq = cur_req ^ N'($urandom & $urandom & $urandom);
            step(($urandom % 200) == 0, rq, ($urandom % 10) == 0, N'($urandom),
                 ($urandom % 3) == 0, ($urandom % 15) == 0);
        end
        idle(3);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || code_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d status and %0d codes left, want 0", exp_q.size(), code_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
